psram_qpi_ctrl: RTL and testbench

PSRAM_QPI_CTRL -- requirements
Module: psram_qpi_ctrl

---
 rtl/psram_pkg.sv | 9 +
 rtl/psram_qpi_ctrl.sv | 143 ++++++++++++++
 tb/tb_psram_qpi_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: controller state encoding and PSRAM command bytes shared by the QPI controller.
package psram_pkg;
    typedef enum logic [3:0] {
        INIT_WAIT, QPI_ENTER, IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, DESEL
    } state_t;
    localparam logic [7:0] CMD_QPI = 8'h35;
    localparam logic [7:0] CMD_WR  = 8'h38;
    localparam logic [7:0] CMD_RD  = 8'hEB;
endpackage

// File: rtl/psram_qpi_ctrl.sv
// psram_qpi_ctrl: 16-bit word host port to a QPI PSRAM; sclk = clk/2, dq driven and sampled on sclk fall.
module psram_qpi_ctrl
    import psram_pkg::*;
#(
    parameter int INIT_CYC  = 30000,
    parameter int WAIT_SCLK = 6,
    parameter int DESEL_CYC = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        init_done,
    output logic        psram_csn,
    output logic        psram_sclk,
    output logic [3:0]  psram_dq_o,
    output logic        psram_dq_oe,
    input  logic [3:0]  psram_dq_i
);
    localparam int CW = $clog2(INIT_CYC + WAIT_SCLK + DESEL_CYC + 8);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [47:0]   sh;
    logic [15:0]   rd_sh;
    logic          we;
    logic          rsp_pend;
    logic          last;

    // terminal count of the shared counter for whichever state is active
    assign last = cnt == CW'(state == INIT_WAIT ? INIT_CYC - 1 :
                             state == QPI_ENTER ? 7 :
                             state == CMD       ? 1 :
                             state == ADDR      ? 5 :
                             state == RWAIT     ? WAIT_SCLK - 1 :
                             state == DESEL     ? DESEL_CYC - 1 : 3);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= INIT_WAIT;
            cnt         <= '0;
            sh          <= '0;
            rd_sh       <= '0;
            we          <= 1'b0;
            rsp_pend    <= 1'b0;
            psram_csn   <= 1'b1;
            psram_sclk  <= 1'b0;
            psram_dq_o  <= '0;
            psram_dq_oe <= 1'b0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            init_done   <= 1'b0;
        end else begin
            rsp_valid <= rsp_pend;
            rsp_pend  <= 1'b0;
            if (rsp_pend) rsp_rdata <= rd_sh;
            if (state inside {QPI_ENTER, CMD, ADDR, WDATA, RWAIT, RDATA}) psram_sclk <= ~psram_sclk;
            // psram_sclk high here means this edge is the falling one: shift, sample, advance
            unique case (state)
                INIT_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state       <= QPI_ENTER;
                        cnt         <= '0;
                        psram_csn   <= 1'b0;
                        psram_dq_oe <= 1'b1;
                        psram_dq_o  <= {3'b0, CMD_QPI[7]};
                        sh          <= {CMD_QPI[6:0], 41'b0};
                    end
                end
                QPI_ENTER: if (psram_sclk) begin
                    cnt        <= cnt + 1'b1;
                    psram_dq_o <= {3'b0, sh[47]};
                    sh         <= sh << 1;
                    if (last) begin
                        state       <= DESEL;
                        cnt         <= '0;
                        psram_csn   <= 1'b1;
                        psram_dq_oe <= 1'b0;
                        psram_dq_o  <= '0;
                    end
                end
                IDLE: if (req_valid && req_ready) begin
                    state       <= CMD;
                    cnt         <= '0;
                    we          <= req_we;
                    req_ready   <= 1'b0;
                    psram_csn   <= 1'b0;
                    psram_dq_oe <= 1'b1;
                    psram_dq_o  <= req_we ? CMD_WR[7:4] : CMD_RD[7:4];
                    sh          <= {req_we ? CMD_WR[3:0] : CMD_RD[3:0], req_addr, req_wdata, 4'b0};
                end
                CMD, ADDR, WDATA: if (psram_sclk) begin
                    cnt        <= cnt + 1'b1;
                    psram_dq_o <= sh[47:44];
                    sh         <= sh << 4;
                    if (last) begin
                        cnt   <= '0;
                        state <= state == CMD ? ADDR : state == WDATA ? DESEL : we ? WDATA : RWAIT;
                        if (state == WDATA || (state == ADDR && !we)) begin
                            psram_dq_oe <= 1'b0;
                            psram_dq_o  <= '0;
                        end
                        if (state == WDATA) psram_csn <= 1'b1;
                    end
                end
                RWAIT: if (psram_sclk) begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= RDATA;
                        cnt   <= '0;
                    end
                end
                RDATA: if (psram_sclk) begin
                    cnt   <= cnt + 1'b1;
                    rd_sh <= {rd_sh[11:0], psram_dq_i};
                    if (last) begin
                        state     <= DESEL;
                        cnt       <= '0;
                        psram_csn <= 1'b1;
                        rsp_pend  <= 1'b1;
                    end
                end
                DESEL: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// tb_psram_qpi_ctrl: random host traffic against a PSRAM device model; frames and read data scoreboarded.
module tb_psram_qpi_ctrl;
    localparam int INIT_CYC  = 16;
    localparam int WAIT_SCLK = 6;
    localparam int DESEL_CYC = 4;
    localparam int MAXC      = 24;

    typedef struct {
        int                  len;
        logic [4*MAXC-1:0]   nib;
        logic [MAXC-1:0]     oe;
        logic [MAXC-1:0]     chk;
        logic [3:0]          mask;
    } frame_t;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        init_done;
    logic        psram_csn;
    logic        psram_sclk;
    logic [3:0]  psram_dq_o;
    logic        psram_dq_oe;
    logic [3:0]  psram_dq_i = '0;

    int n_chk = 0;
    int n_fail = 0;

    frame_t     exp_frames[$];
    logic [15:0] exp_rsp[$];
    logic [7:0] ref_mem[int];
    logic [7:0] dev_mem[int];
    bit         first_after_init = 1'b0;

    psram_qpi_ctrl #(.INIT_CYC(INIT_CYC), .WAIT_SCLK(WAIT_SCLK), .DESEL_CYC(DESEL_CYC)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .psram_csn(psram_csn), .psram_sclk(psram_sclk), .psram_dq_o(psram_dq_o),
        .psram_dq_oe(psram_dq_oe), .psram_dq_i(psram_dq_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // contents of never-written PSRAM bytes, shared by device model and reference
    function automatic logic [7:0] init_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ ~a[23:16];
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [23:0] a);
        return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic frame_t qpi_frame();
        frame_t f;
        logic [7:0] q;
        q = 8'h35;
        f.len = 8; f.nib = '0; f.oe = '0; f.chk = '0; f.mask = 4'h1;
        for (int k = 0; k < 8; k++) begin
            f.nib[4*k +: 4] = {3'b0, q[7-k]};
            f.oe[k] = 1'b1;
            f.chk[k] = 1'b1;
        end
        return f;
    endfunction

    function automatic frame_t req_frame(input logic we, input logic [23:0] a, input logic [15:0] d);
        frame_t f;
        logic [47:0] bits;
        bits = {(we ? 8'h38 : 8'hEB), a, d};
        f.len = we ? 12 : 12 + WAIT_SCLK; f.nib = '0; f.oe = '0; f.chk = '0; f.mask = 4'hF;
        for (int k = 0; k < f.len; k++) begin
            f.oe[k] = we || k < 8;
            f.chk[k] = f.oe[k];
            if (k < 12) f.nib[4*k +: 4] = bits[47-4*k -: 4];
        end
        return f;
    endfunction

    // called at a negedge; returns at the negedge after the handshake edge
    task automatic issue(input logic we, input logic [23:0] a, input logic [15:0] d, input bit hold);
        int t;
        t = 0;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            check("req_accept_timeout", t, 0);
            req_valid = 1'b0;
            return;
        end
        exp_frames.push_back(req_frame(we, a, d));
        if (we) begin
            ref_mem[int'(a)] = d[15:8];
            ref_mem[int'(a + 24'd1)] = d[7:0];
        end else exp_rsp.push_back({ref_rd(a), ref_rd(a + 24'd1)});
        @(negedge clk);
        req_addr = 24'($urandom); req_wdata = 16'($urandom); req_we = 1'($urandom);
        if (!hold) req_valid = 1'b0;
    endtask

    // PSRAM device model and frame capture, both keyed on sclk rising edges
    int          pn, fn, gap;
    logic [7:0]  pc;
    logic [23:0] pa;
    logic [15:0] pd, prd;
    logic        p_sclk, p_csn;
    logic [4*MAXC-1:0] got_nib, mvec;
    logic [MAXC-1:0]   got_oe;
    always @(negedge clk) begin
        if (arst) begin
            pn = 0; fn = 0; gap = 0; got_nib = '0; got_oe = '0;
        end else begin
            if (!psram_csn && p_csn) begin
                check("desel_gap_ok", gap >= DESEL_CYC, 1);
                pn = 0; fn = 0; got_nib = '0; got_oe = '0;
            end
            if (psram_csn) gap++;
            else gap = 0;
            if (!psram_csn && psram_sclk && !p_sclk) begin
                pn++;
                if (fn < MAXC) begin
                    got_nib[4*fn +: 4] = psram_dq_o;
                    got_oe[fn] = psram_dq_oe;
                end
                fn++;
                if (pn <= 2) pc = {pc[3:0], psram_dq_o};
                else if (pn <= 8) pa = {pa[19:0], psram_dq_o};
                else if (pc == 8'h38 && pn <= 12) begin
                    pd = {pd[11:0], psram_dq_o};
                    if (pn == 12) begin
                        dev_mem[int'(pa)] = pd[15:8];
                        dev_mem[int'(pa + 24'd1)] = pd[7:0];
                    end
                end
                if (pc == 8'hEB && pn == 8) prd = {dev_rd(pa), dev_rd(pa + 24'd1)};
                psram_dq_i = (pc == 8'hEB && pn > 8 + WAIT_SCLK && pn <= 12 + WAIT_SCLK)
                             ? prd[4*(12 + WAIT_SCLK - pn) +: 4] : 4'($urandom);
            end
            if (psram_csn && !p_csn) begin
                check("frame_expected", exp_frames.size() > 0, 1);
                if (exp_frames.size() > 0) begin
                    frame_t e;
                    e = exp_frames.pop_front();
                    for (int k = 0; k < MAXC; k++) mvec[4*k +: 4] = e.chk[k] ? e.mask : 4'h0;
                    check("frame_len", fn, e.len);
                    check("frame_dq", got_nib & mvec, e.nib & mvec);
                    check("frame_oe", got_oe, e.oe);
                end
            end
        end
        p_sclk = psram_sclk;
        p_csn = psram_csn;
    end

    // response scoreboard and per-cycle pin rules
    logic        prev_rv, prev_init;
    logic [15:0] last_rsp;
    always @(negedge clk) begin
        if (arst) begin
            prev_rv = 1'b0; prev_init = 1'b0; last_rsp = '0;
        end else begin
            if (rsp_valid) begin
                check("rsp_single_pulse", prev_rv, 0);
                check("rsp_expected", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
                last_rsp = rsp_rdata;
            end else check("rsp_rdata_hold", rsp_rdata, last_rsp);
            if (psram_csn) check("idle_sclk_oe", {psram_sclk, psram_dq_oe}, 0);
            else check("ready_while_busy", req_ready, 0);
            check("ready_needs_init", req_ready & ~init_done, 0);
            if (req_valid && req_ready && first_after_init) begin
                check("accept_first_idle", {init_done, prev_init}, 2'b10);
                first_after_init = 1'b0;
            end
            prev_rv = rsp_valid;
            prev_init = init_done;
        end
    end

    initial begin
        logic [23:0] a;
        logic [15:0] d;
        logic        we;
        bit          hold;
        #1 arst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csn", psram_csn, 1);
        check("rst_sclk", psram_sclk, 0);
        check("rst_oe", psram_dq_oe, 0);
        check("rst_dq_o", psram_dq_o, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_init_done", init_done, 0);
        // request held from reset release must wait for the first IDLE cycle
        exp_frames.push_back(qpi_frame());
        first_after_init = 1'b1;
        arst = 1'b0;
        issue(1'b1, 24'h123456, 16'hA55A, 1'b0);
        issue(1'b0, 24'h123456, 16'h0000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 2) == 0) ? 24'hFFFFFF : 24'(32'h400 + $urandom_range(0, 5));
            d = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 1) == 1 && i != 39;
            issue(we, a, d, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int t = 0; t < 300 && (exp_frames.size() > 0 || exp_rsp.size() > 0); t++) @(negedge clk);
        check("drain_frames", exp_frames.size(), 0);
        check("drain_rsp", exp_rsp.size(), 0);
        // abort a read in its address phase
        repeat (2) @(negedge clk);
        issue(1'b0, 24'h000401, 16'h0000, 1'b0);
        repeat (6) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check("abort_csn", psram_csn, 1);
        check("abort_sclk", psram_sclk, 0);
        check("abort_oe", psram_dq_oe, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_init_done", init_done, 0);
        exp_frames.delete();
        exp_rsp.delete();
        repeat (3) @(negedge clk);
        exp_frames.push_back(qpi_frame());
        first_after_init = 1'b1;
        arst = 1'b0;
        req_we = 1'b0; req_addr = 24'h123456; req_valid = 1'b1;
        repeat (INIT_CYC) @(negedge clk);
        check("reinit_init_done_low", init_done, 0);
        issue(1'b0, 24'h123456, 16'h0000, 1'b0);
        issue(1'b1, 24'hFFFFFF, 16'h1234, 1'b0);
        issue(1'b0, 24'hFFFFFF, 16'h0000, 1'b0);
        for (int t = 0; t < 300 && (exp_frames.size() > 0 || exp_rsp.size() > 0); t++) @(negedge clk);
        check("final_drain_frames", exp_frames.size(), 0);
        check("final_drain_rsp", exp_rsp.size(), 0);
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
